// File: rtl/three_way_bus_arbiter_pkg.sv
// Shared types and constants for the three-way round-robin bus arbiter.
package arb_pkg;

    localparam int DATA_W = 9;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_REQ0 = 2'b00;
    localparam sel_t SEL_REQ1 = 2'b01;
    localparam sel_t SEL_REQ2 = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [2:0] sel_onehot(input sel_t s);
        logic [2:0] r;
        case (s)
            SEL_REQ0: r = 3'b001;
            SEL_REQ1: r = 3'b010;
            SEL_REQ2: r = 3'b100;
            default:  r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/three_way_bus_arbiter_mux3.sv
// Three-input word mux shared by the datapath; select 2'b11 yields zero.
module mux3_9
    import arb_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  sel_t             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = '0;
        case (sel)
            SEL_REQ0: out = in0;
            SEL_REQ1: out = in1;
            SEL_REQ2: out = in2;
            default:  out = '0;
        endcase
    end

endmodule

// File: rtl/three_way_bus_arbiter_rr_pick.sv
// Round-robin winner selection: priority starts just after last_grant.
module rr_pick
    import arb_pkg::*;
(
    input  logic [2:0] req,
    input  sel_t       last_grant,
    output logic       any,
    output sel_t       winner
);

    always_comb begin
        any    = |req;
        winner = SEL_REQ0;
        case (last_grant)
            SEL_REQ0: begin
                if (req[1])      winner = SEL_REQ1;
                else if (req[2]) winner = SEL_REQ2;
                else             winner = SEL_REQ0;
            end
            SEL_REQ1: begin
                if (req[2])      winner = SEL_REQ2;
                else if (req[0]) winner = SEL_REQ0;
                else             winner = SEL_REQ1;
            end
            default: begin
                if (req[0])      winner = SEL_REQ0;
                else if (req[1]) winner = SEL_REQ1;
                else             winner = SEL_REQ2;
            end
        endcase
    end

endmodule

// File: rtl/three_way_bus_arbiter.sv
// Round-robin arbiter: captures the winning word and offers it downstream
// on a valid/ready handshake, acking the source on accept.
module three_way_bus_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] data_0,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [2:0]       ack
);

    state_t           r_state;
    state_t           w_state_nxt;
    sel_t             r_sel;
    sel_t             w_sel_nxt;
    sel_t             r_last;
    sel_t             w_last_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;

    logic [2:0]       w_pick_req;
    sel_t             w_pick_last;
    logic             w_any;
    sel_t             w_winner;
    logic [WIDTH-1:0] w_mux;

    // On an accept the just-served source is masked and the pointer
    // advances to it, so the pick already reflects the updated order.
    always_comb begin
        w_pick_req  = req;
        w_pick_last = r_last;
        if (r_state == BUSY) begin
            w_pick_req  = req & ~sel_onehot(r_sel);
            w_pick_last = r_sel;
        end
    end

    rr_pick u_pick (
        .req        (w_pick_req),
        .last_grant (w_pick_last),
        .any        (w_any),
        .winner     (w_winner)
    );

    mux3_9 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel (w_winner),
        .in0 (data_0),
        .in1 (data_1),
        .in2 (data_2),
        .out (w_mux)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_data_nxt  = r_data;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = BUSY;
                    w_sel_nxt   = w_winner;
                    w_data_nxt  = w_mux;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    w_last_nxt = r_sel;
                    if (w_any) begin
                        w_sel_nxt  = w_winner;
                        w_data_nxt = w_mux;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= SEL_REQ0;
            r_last  <= SEL_REQ2;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign out_valid = (r_state == BUSY);
    assign sel       = r_sel;
    assign out_data  = r_data;
    assign ack       = (out_valid && out_ready) ? sel_onehot(r_sel) : 3'b000;

endmodule

// File: doc/three_way_bus_arbiter.md
Name: three_way_bus_arbiter

Overview:
- Round-robin arbiter sharing one 9-bit datapath between three requesters.
- Drives the 2-bit select of the team's existing three-input 9-bit mux and registers the winning word.
- Presents the registered word downstream through a valid/ready handshake.
- Returns a one-cycle ack to the requester whose word is accepted. Sits between producer blocks and any single-consumer resource in the datapath.

Parameters:
WIDTH, 9, data word width; must match the mux width (9); other values unsupported.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous reset, active-low.
req  input  3  req[i] = requester i has a word on data_i.
data_0  input  WIDTH  requester 0 word.
data_1  input  WIDTH  requester 1 word.
data_2  input  WIDTH  requester 2 word.
sel  output  2  current grant index (00/01/10) and mux select; 11 never driven.
out_valid  output  1  out_data holds an unaccepted word.
out_data  output  WIDTH  registered word of the granted requester.
out_ready  input  1  downstream accepts when out_valid && out_ready.
ack  output  3  one-hot; ack[i] high in the accept cycle of requester i's word.

Behaviour:
- Interface is fixed: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset, sampled at a clk edge with rst_n=0, sets:
  - state=IDLE.
  - out_valid=0, out_data=0, sel=2'b00.
  - last_grant=2'b10, so requester 0 has top priority first.
  - ack=0. ack is combinational and is therefore 0 whenever out_valid=0.
- Priority order after last_grant g: (g+1)%3, (g+2)%3, g.
- States: IDLE, BUSY.
- IDLE:
  - If req!=0 at the edge, pick winner w by priority.
  - Register sel<=w and out_data<=data_w (through the three-input mux), out_valid<=1, go to BUSY.
  - Latency is one edge: req high before edge N gives out_valid high after edge N.
- BUSY:
  - out_valid=1.
  - out_data and sel hold until accept, whatever data_x and req do. The word is captured at grant, so requesters may change data after grant.
  - ack[i] = out_valid & out_ready & (sel==i), combinational.
- Accept edge (out_ready=1 in BUSY):
  - last_grant<=sel.
  - Masked request = req with bit sel cleared, so the just-acked requester cannot win back-to-back.
  - If masked request is nonzero: pick the next winner with the updated pointer, load sel/out_data, stay in BUSY. out_valid stays 1 with no bubble.
  - Otherwise go to IDLE with out_valid<=0.
- Sole requester holding req continuously is granted every other cycle (IDLE bubble between grants).
- Requester deasserts req after grant but before ack: the transaction is not cancelled, and the ack still fires on accept.
- out_ready=1 in IDLE: no effect.
- Reset asserted mid-BUSY: the pending word is dropped, no ack, and everything returns to reset values at that edge.
- Simultaneous req rise and accept: the rising requester takes part in the accept-edge pick.
- No X ever driven on sel, out_data or ack after reset.

Decomposition:
- Package arb_pkg:
  - typedef sel_t (logic [1:0]).
  - constants SEL_REQ0=2'b00, SEL_REQ1=2'b01, SEL_REQ2=2'b10.
  - enum state_t {IDLE, BUSY}.
  - DATA_W=9.
- Sub-module rr_pick, combinational: inputs req[2:0] and last_grant; outputs any and winner.
- Data path instantiates the existing three-input 9-bit mux with sel driven from rr_pick's winner.

Test Plan:
1. rst_n=0 for 2 cycles with random req/data -> out_valid=0, out_data=0, sel=00, ack=000. Then req=111 -> first grant sel=00.
2. req=010, data_1=9'h1A5, out_ready=1 -> out_valid=1, out_data=9'h1A5, sel=01 one edge later. ack=010 for exactly one cycle, then IDLE with out_valid=0.
3. req=111 held, out_ready=1, data_i=9'h100+i -> sel sequence 00,01,10,00,01,10 on consecutive cycles. out_valid continuously 1, ack one-hot rotating.
4. Grant req0 with data_0=9'h0F0, out_ready=0 for 5 cycles while data_0 toggles -> out_data stays 9'h0F0, sel=00, ack=000. On out_ready=1, ack=001 once.
5. Only req[2] held high, out_ready=1 -> out_valid pattern 1,0,1,0. ack[2] on each valid cycle, sel=10 throughout.
6. In BUSY with out_ready=0, assert rst_n=0 for one edge -> next cycle out_valid=0, ack never asserted. With req=011 afterwards, next grant is sel=00 (pointer reset).
